note_sequencer: RTL
===================

# note_sequencer

Queues note codes arriving from the UART receiver and plays them back one at a time, each for a fixed duration followed by a fixed silent gap, so that rapid key presses are heard in order instead of cutting each other off. Sits between the UART receive path and the PWM tone generator. It replaces ad-hoc "new note" edge detection with a strobe-driven FIFO and a playback state machine. It drives the tone generator's note code and enable.

## Interface

Parameters:
- note_cycles, default 25_000_000: clocks per played note (0.25 s at 100 MHz); must be ≥ 1.
- gap_cycles, default 2_500_000: silent clocks after each note (25 ms); must be ≥ 1.
- fifo_depth, default 8: queue entries; power of two, 2..16.

Ports (clk and reset first):
- clk, input, 1: 100 MHz board clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- note_valid, input, 1: one-cycle strobe; note_code is valid in this cycle.
- note_code, input, 8: key code; only 2..11 are playable.
- flush, input, 1: clears the queue and aborts playback; level-sampled each cycle.
- play_note, output, 8: note code to the tone generator.
- play_active, output, 1: tone enable to the tone generator.
- queue_count, output, 5: number of waiting notes, excluding the one playing.
- overflow, output, 1: sticky flag; a valid note was dropped because the queue was full.
- busy, output, 1: high when the state is not IDLE.

## Operation

- **Reset** (reset = 0 at a clock edge):
  - play_note = 0, play_active = 0, queue_count = 0, overflow = 0, busy = 0.
  - State = IDLE; FIFO pointers = 0; counter = 0.
- **Push**: a note is accepted when note_valid = 1, note_code is in 2..11, flush = 0, and the FIFO is not full after accounting for a pop in the same cycle.
  - Codes 0, 1 and 12..255 are silently ignored and do not set overflow.
- **Full**: a valid note arriving while full with no same-cycle pop is dropped and sets overflow = 1. The queue contents are unchanged.
- **Simultaneous push and pop**: both take effect. queue_count is unchanged. This works even when the queue is full.
- **State machine** (all outputs registered):
  - IDLE: play_active = 0. If the FIFO is not empty, pop the head into play_note, clear the counter, go to PLAY.
  - PLAY: play_active = 1. The counter counts 0..note_cycles−1; at note_cycles−1, clear the counter and go to GAP.
  - GAP: play_active = 0 and play_note holds its value. The counter counts 0..gap_cycles−1. At gap_cycles−1:
    - if the FIFO is not empty, pop the head into play_note, clear the counter, go to PLAY;
    - otherwise go to IDLE.
- **Flush** (highest priority after reset):
  - Clears the FIFO pointers, queue_count and overflow; state = IDLE; play_active = 0 from the next cycle.
  - play_note keeps its last value.
  - A note_valid in the same cycle is dropped.
- **Counter**: 32-bit unsigned; it never wraps because it is cleared on every state change.
- **FIFO**: pointers are log2(fifo_depth)+1 bits wide. Full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.

## Timing

- **Start latency**: note_valid sampled in cycle T with the queue empty and state IDLE gives queue_count = 1 in T+1, then play_active = 1 and play_note = code in T+2, with queue_count back to 0 in T+2.
- **Note length**: play_active is high for exactly note_cycles consecutive cycles, then low for exactly gap_cycles cycles.
- **Back-to-back notes**: the next note's play_active rises on the cycle after the last gap cycle. The note period is note_cycles + gap_cycles.
- **Gap-to-idle**: with an empty queue at the end of GAP, busy falls one cycle after the last gap cycle.
- **Reset or flush mid-note**: play_active is 0 in the next cycle; no partial gap is played.
- **Output timing**: overflow and queue_count update on the clock edge after the causing event.

## Test plan

- Reset: hold reset = 0 for 3 cycles, with note_valid pulsed during reset → all outputs 0 and no playback after release.
- Single note (note_cycles = 4, gap_cycles = 2): push code 5 at T → play_note = 5 and play_active high during T+2..T+5, low during T+6..T+7, busy = 0 at T+8.
- Filter: push codes 0, 1, 12 and 200 → queue_count stays 0, overflow stays 0, play_active never rises.
- Overflow (fifo_depth = 4, long note_cycles): push 2,3,4,5,6,7 on consecutive cycles → 2 plays, queue_count = 4, code 7 is dropped, overflow = 1; playback order is 2,3,4,5,6.
- Flush mid-PLAY with 3 notes queued → play_active = 0 next cycle, queue_count = 0, overflow = 0, state IDLE. A note_valid in the flush cycle is not played.
- Push exactly on the last GAP cycle with an empty queue → that note starts via the IDLE path; check that no cycle has play_active high with a stale play_note.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Note sequencer bus: the note strobe and flush toward the sequencer, and the playback status back from it.
interface note_sequencer_if;
    logic       note_valid;
    logic [7:0] note_code;
    logic       flush;
    logic [7:0] play_note;
    logic       play_active;
    logic [4:0] queue_count;
    logic       overflow;
    logic       busy;

    modport master (
        output note_valid, note_code, flush,
        input  play_note, play_active, queue_count, overflow, busy
    );

    modport slave (
        input  note_valid, note_code, flush,
        output play_note, play_active, queue_count, overflow, busy
    );
endinterface

// File: rtl/note_sequencer.sv
// Note queue plus playback FSM: each queued note plays for note_cycles and is followed by a silent gap.
// Notes are played in the order they arrive.
module note_sequencer #(
    parameter int unsigned note_cycles = 25_000_000,
    parameter int unsigned gap_cycles  = 2_500_000,
    parameter int unsigned fifo_depth  = 8
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int unsigned AW        = $clog2(fifo_depth);
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_PLAY    = 2'd1;
    localparam logic [1:0]  S_GAP     = 2'd2;
    localparam logic [31:0] NOTE_LAST = 32'(note_cycles - 32'd1);
    localparam logic [31:0] GAP_LAST  = 32'(gap_cycles - 32'd1);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    function automatic logic is_playable(input logic [7:0] code);
        return (code >= 8'd2) && (code <= 8'd11);
    endfunction

    logic [7:0]  r_mem [fifo_depth];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_play_note;
    logic        r_play_active;
    logic [4:0]  r_queue_count;
    logic        r_overflow;
    logic        r_busy;

    logic w_empty;
    logic w_full;
    logic w_pop_raw;
    logic w_pop;
    logic w_accept;
    logic w_push;
    logic w_drop;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_accept = bus.note_valid && is_playable(bus.note_code) && !bus.flush;
    assign w_pop    = w_pop_raw && !bus.flush;
    // A same-cycle pop frees a slot, so a full queue can still take a note.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;

    // Decide whether the FSM takes the head note this cycle.
    always_comb begin
        w_pop_raw = 1'b0;
        case (r_state)
            S_IDLE:  w_pop_raw = !w_empty;
            S_GAP:   w_pop_raw = !w_empty && (r_cnt == GAP_LAST);
            default: w_pop_raw = 1'b0;
        endcase
    end

    // Queue storage; pointer reset alone empties it, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.note_code;
        end
    end

    // Queue pointers, status flags and the playback state machine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_state       <= S_IDLE;
            r_cnt         <= 32'd0;
            r_play_note   <= 8'd0;
            r_play_active <= 1'b0;
            r_queue_count <= 5'd0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
        end else if (bus.flush) begin
            // play_note is left alone so the tone generator keeps a sane code.
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_state       <= S_IDLE;
            r_cnt         <= 32'd0;
            r_play_active <= 1'b0;
            r_queue_count <= 5'd0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_drop) r_overflow <= 1'b1;
            r_queue_count <= r_queue_count + {4'd0, w_push} - {4'd0, w_pop};
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_play_note   <= r_mem[r_rd_ptr[AW-1:0]];
                        r_cnt         <= 32'd0;
                        r_state       <= S_PLAY;
                        r_play_active <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (r_cnt == NOTE_LAST) begin
                        r_cnt         <= 32'd0;
                        r_state       <= S_GAP;
                        r_play_active <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= 32'd0;
                        if (w_pop) begin
                            r_play_note   <= r_mem[r_rd_ptr[AW-1:0]];
                            r_state       <= S_PLAY;
                            r_play_active <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cnt         <= 32'd0;
                    r_play_active <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.play_note   = r_play_note;
    assign bus.play_active = r_play_active;
    assign bus.queue_count = r_queue_count;
    assign bus.overflow    = r_overflow;
    assign bus.busy        = r_busy;
endmodule
